// File: rtl/button_operation_encoder.sv
// button_operation_encoder: synchronise, debounce, edge-detect and arbitrate five buttons into a one-hot command pulse.
// Define AUTO_REPEAT_EN to re-issue a held direction command after REPEAT_DELAY, then every REPEAT_PERIOD cycles.
module button_operation_encoder #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int SYNC_STAGES     = 2
`ifdef AUTO_REPEAT_EN
    ,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_PERIOD   = 15000000
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] btn,
    output logic [4:0] operation,
    output logic       btn_held
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    typedef enum logic {IDLE, HOLD} state_t;
    state_t state, state_nx;
    logic [SYNC_STAGES-1:0][4:0] sync;
    logic [4:0][CW-1:0] cnt;
    logic [4:0] s, d, d_q, rise, pick, op_nx;
    assign s = sync[SYNC_STAGES-1];
    // lowest set bit wins: confirm > left > right > up > down
    assign pick = rise & (~rise + 5'd1);
    assign btn_held = state == HOLD;
    always_ff @(posedge clk) begin
        if (rst) begin
            sync <= '0;
            cnt  <= '0;
            d    <= '0;
            d_q  <= '0;
            rise <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], btn};
            d_q  <= d;
            rise <= d & ~d_q;
            for (int i = 0; i < 5; i++) begin
                if (s[i] == d[i]) cnt[i] <= '0;
                else if (cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
                    d[i]   <= s[i];
                    cnt[i] <= '0;
                end else cnt[i] <= cnt[i] + CW'(1);
            end
        end
    end
`ifdef AUTO_REPEAT_EN
    localparam int RMAX = REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW = $clog2(RMAX + 1);
    logic [4:0] cur, cur_nx;
    logic [RW-1:0] rcnt, rcnt_nx;
    logic rep, rep_nx;
    always_ff @(posedge clk) begin
        if (rst) begin
            cur  <= '0;
            rcnt <= '0;
            rep  <= 1'b0;
        end else begin
            cur  <= cur_nx;
            rcnt <= rcnt_nx;
            rep  <= rep_nx;
        end
    end
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            operation <= '0;
        end else begin
            state     <= state_nx;
            operation <= op_nx;
        end
    end
    always_comb begin
        state_nx = state;
        op_nx    = '0;
        if (state == IDLE && rise != '0) begin
            state_nx = HOLD;
            op_nx    = pick;
        end else if (state == HOLD && d == '0) state_nx = IDLE;
`ifdef AUTO_REPEAT_EN
        cur_nx  = state == IDLE ? pick : cur;
        rcnt_nx = '0;
        rep_nx  = 1'b0;
        if (state == HOLD && !cur[0] && (d & cur) != '0) begin
            rep_nx = rep;
            if (rcnt == (rep ? RW'(REPEAT_PERIOD - 1) : RW'(REPEAT_DELAY - 1))) begin
                op_nx   = cur;
                rcnt_nx = '0;
                rep_nx  = 1'b1;
            end else rcnt_nx = rcnt + RW'(1);
        end
`endif
    end
endmodule

// File: tb/tb_button_operation_encoder.sv
// tb_button_operation_encoder: scoreboard bench; expected pulses (value, cycle) are queued as buttons are driven.
module tb_button_operation_encoder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [4:0] btn = '0;
    logic [4:0] operation;
    logic btn_held;
    int cyc = 0;
    int checks = 0;
    int errors = 0;
    typedef struct {logic [4:0] op; int cyc;} exp_t;
    exp_t sb[$];

    button_operation_encoder #(
        .DEBOUNCE_CYCLES(4),
        .SYNC_STAGES(2)
`ifdef AUTO_REPEAT_EN
        ,
        .REPEAT_DELAY(20),
        .REPEAT_PERIOD(8)
`endif
    ) dut (
        .clk(clk),
        .rst(rst),
        .btn(btn),
        .operation(operation),
        .btn_held(btn_held)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && operation != '0) begin
            check("onehot", 32'($onehot0(operation)), 1);
            if (sb.size() == 0) check("spurious", 32'(operation), 0);
            else begin
                e = sb.pop_front();
                check("op", 32'(operation), 32'(e.op));
                check("op_cyc", cyc, e.cyc);
            end
        end
    end

    // Button set at cycle c is first sampled at edge c+1; pulse lands 7 edges later.
    // Repeats fire while the debounced level (dropping 6 edges after release) is still high.
    task automatic expect_pulses(logic [4:0] op, int c, int rel);
        sb.push_back('{op, c + 8});
`ifdef AUTO_REPEAT_EN
        if (!op[0])
            for (int t = c + 28; t <= rel + 6; t += 8) sb.push_back('{op, t});
`endif
    endtask

    task automatic press(logic [4:0] b, logic [4:0] op, int hold);
        int c = cyc;
        btn = b;
        expect_pulses(op, c, c + hold);
        repeat (hold) @(negedge clk);
        check("held", 32'(btn_held), 1);
        btn = '0;
        repeat (12) @(negedge clk);
        check("idle", 32'(btn_held), 0);
    endtask

    initial begin
        int c;
        logic [9:0] pat_press;
        logic [9:0] pat_rel;
        pat_press = 10'b1011010010;
        pat_rel   = 10'b0100110100;
        repeat (3) @(negedge clk);
        check("rst_op", 32'(operation), 0);
        check("rst_held", 32'(btn_held), 0);
        rst = 1'b0;
        @(negedge clk);
        press(5'b00100, 5'b00100, 30);
        for (int n = 0; n < 10; n++) begin
            btn = 5'b00001;
            repeat (3) @(negedge clk);
            btn = '0;
            repeat (5) @(negedge clk);
        end
        check("glitch_held", 32'(btn_held), 0);
        // simultaneous rises: only the higher-priority bit issues; FSM waits for all releases
        c = cyc;
        btn = 5'b11000;
        expect_pulses(5'b01000, c, c + 12);
        repeat (12) @(negedge clk);
        btn = 5'b10000;
        repeat (15) @(negedge clk);
        check("chord_held", 32'(btn_held), 1);
        btn = '0;
        repeat (12) @(negedge clk);
        check("chord_idle", 32'(btn_held), 0);
        press(5'b10101, 5'b00001, 10);
        // bouncy press and release
        for (int i = 9; i >= 0; i--) begin
            btn = {1'b0, pat_press[i], 3'b000};
            @(negedge clk);
        end
        c = cyc;
        btn = 5'b01000;
        expect_pulses(5'b01000, c, c + 18);
        repeat (10) @(negedge clk);
        for (int i = 9; i >= 0; i--) begin
            btn = {1'b0, pat_rel[i], 3'b000};
            @(negedge clk);
        end
        btn = '0;
        repeat (12) @(negedge clk);
        check("bounce_idle", 32'(btn_held), 0);
        // reset mid-hold, button kept down
        c = cyc;
        btn = 5'b00010;
        expect_pulses(5'b00010, c, c + 12);
        repeat (12) @(negedge clk);
        check("pre_rst_held", 32'(btn_held), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_op", 32'(operation), 0);
        check("mid_rst_held", 32'(btn_held), 0);
        c = cyc;
        expect_pulses(5'b00010, c, c + 12);
        repeat (12) @(negedge clk);
        check("post_rst_held", 32'(btn_held), 1);
        btn = '0;
        repeat (12) @(negedge clk);
        check("post_rst_idle", 32'(btn_held), 0);
        press(5'b10000, 5'b10000, 60);
        press(5'b00001, 5'b00001, 60);
        repeat (10) @(negedge clk);
        check("pending", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
